multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle sequencer for the RV32I core. Replaces single-cycle decode with a
//  FETCH/DECODE/EXEC/MEM/WB state machine. Handshakes with wait-stated instruction
//  and data memories, holds the IR, and drives the shared ALU/extender/regfile/PC
//  strobes. It traps on illegal encodings and on memory timeouts.
// PARAMETERS
//  MAX_WAIT  16  memory wait-cycle limit before bus error; 0 = watchdog disabled
//  WAIT_W    8   watchdog counter width; must satisfy MAX_WAIT < 2**WAIT_W
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   reset, synchronous, active-low
//  imem_req     out  1   instruction fetch request
//  imem_ready   in   1   fetch data valid this cycle
//  imem_rdata   in   32  fetched instruction
//  dmem_req     out  1   data access request; held until dmem_ready
//  dmem_we      out  1   1 = store, 0 = load; valid while dmem_req
//  dmem_size    out  2   01 word, 10 half, 11 byte
//  dmem_uns     out  1   unsigned load (LBU/LHU)
//  dmem_ready   in   1   data access complete this cycle
//  br_cond      in   1   datapath comparator result for the current branch funct3
//  ir_o         out  32  latched instruction register
//  alu_ctrl     out  4   ADD0 SUB1 SLT2 SLTU3 XOR4 OR5 AND6 SLL7 SRL8 SRA9
//  alu_src      out  1   1 = immediate operand B
//  imm_src      out  3   I000 S001 B010 U011 J100 R111
//  result_src   out  2   00 ALU, 01 memory, 10 PC+4, 11 imm/AUIPC sum
//  reg_write    out  1   one-cycle register-file write strobe
//  pc_we        out  1   one-cycle PC update strobe
//  pc_src       out  2   00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
//  illegal      out  1   sticky: illegal instruction trap
//  bus_err      out  1   sticky: memory watchdog trap
//  state_o      out  3   FETCH0 DECODE1 EXEC2 MEM3 WB4 TRAP5
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=FETCH, ir_o=32'h00000013, watchdog=0.
//    illegal=bus_err=0. All strobes and requests are 0 during the reset cycle.
//    Reset mid-MEM drops dmem_req on the next cycle with no retry.
//  - FETCH: imem_req=1. On imem_ready, latch IR and go to DECODE.
//    imem_ready outside FETCH is ignored.
//  - DECODE: classify the IR. Illegal -> TRAP, else EXEC. Illegal encodings:
//    unknown opcode; branch f3 010/011; load f3 011/110/111; store f3>010;
//    JALR f3!=0; R-type f7 not 0000000/0100000 (0100000 is legal only for
//    ADD/SUB and SRL/SRA).
//  - EXEC, by opcode class:
//      LOAD/STORE -> MEM.
//      BRANCH -> pc_we=1 with pc_src=01 if br_cond else 00, then FETCH.
//      All others -> WB.
//  - MEM: dmem_req=1 each cycle until dmem_ready (zero-wait allowed).
//      Store + ready -> pc_we=1, pc_src=00, then FETCH.
//      Load + ready -> WB.
//  - WB: reg_write=1 and pc_we=1 in the same cycle, then FETCH.
//      JAL: pc_src=01, result_src=10. JALR: pc_src=10, result_src=10.
//      Load: result_src=01. LUI/AUIPC: result_src=11. Otherwise 00.
//  - TRAP: all strobes/requests 0; stays until reset.
//  - Decode outputs (alu_ctrl, alu_src, imm_src, result_src, dmem_size,
//    dmem_uns) are combinational from the IR and stable from DECODE to WB.
//    In FETCH/TRAP they are 0; imm_src=111.
//  - Latency with zero wait: R/I/U/JAL/JALR 4 cycles, load 5, store 4, branch 3.
//  - Watchdog: counts cycles with a request high and ready low.
//    Cleared on ready or state change. Reaching MAX_WAIT -> bus_err=1, TRAP.
//  - rd=x0 writes are still strobed; the register file discards them.
// CONFIGURATION
//  MC_PERF_CNT_EN defined:
//    - adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0.
//    - cycle_cnt increments every cycle outside TRAP.
//    - instret_cnt increments on each pc_we.
//    - both wrap mod 2^32.
//  MC_PERF_CNT_EN undefined: these ports and registers do not exist.
// TESTING
//  - reset=0 for 2 cycles, imem_ready=1 -> state_o=0 and all strobes 0 during reset;
//    imem_req=1 in the first cycle after release.
//  - ADD x3,x1,x2 (32'h002081B3), zero wait -> states 0,1,2,4; alu_ctrl=0000;
//    reg_write and pc_we high only in cycle 4.
//  - LW x5,8(x0) (32'h00802283), dmem_ready after 3 waits -> dmem_req high 4 cycles;
//    dmem_size=01, dmem_we=0; reg_write with result_src=01 one cycle later.
//  - BEQ x0,x0,+8 (32'h00000463), br_cond=1 -> pc_we=1, pc_src=01 in EXEC;
//    3 cycles total; reg_write never asserts.
//  - IR=32'h0000007F -> illegal=1, state_o=5 from the cycle after DECODE;
//    imem_req stays 0 until reset.
//  - MAX_WAIT=4, SW (32'h00112023), dmem_ready=0 -> bus_err=1 after 4 wait cycles;
//    dmem_req drops; no pc_we.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core, with IR, memory
// handshakes, illegal-instruction and bus-watchdog traps. Optional counters: MC_PERF_CNT_EN.
module multicycle_ctrl_fsm #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [1:0]  dmem_size,
  output logic        dmem_uns,
  input  logic        dmem_ready,
  input  logic        br_cond,
  output logic [31:0] ir_o,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src,
  output logic [2:0]  imm_src,
  output logic [1:0]  result_src,
  output logic        reg_write,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        illegal,
  output logic        bus_err,
`ifdef MC_PERF_CNT_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt,
`endif
  output logic [2:0]  state_o
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [31:0] IR_NOP = 32'h0000_0013;

  logic [2:0]        state, state_nxt;
  logic [31:0]       ir;
  logic [WAIT_W-1:0] wd, wd_nxt;
  logic              set_ill, set_be;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_op, is_opimm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic       legal, alt;
  logic [3:0] alu_base;
  logic       dec_active;
  logic       waiting, timeout;

  assign opcode    = ir[6:0];
  assign f3        = ir[14:12];
  assign f7        = ir[31:25];
  assign is_op     = (opcode == OPC_OP);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);

  assign ir_o    = ir;
  assign state_o = state;

  // Encoding legality check on the latched IR
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_OP:     legal = (f7 == 7'b0000000) ||
                          ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      OPC_BRANCH: legal = (f3 != 3'b010) && (f3 != 3'b011);
      OPC_LOAD:   legal = (f3 != 3'b011) && (f3[2:1] != 2'b11);
      OPC_STORE:  legal = (f3 <= 3'b010);
      OPC_JALR:   legal = (f3 == 3'b000);
      OPC_OPIMM, OPC_JAL, OPC_LUI, OPC_AUIPC: legal = 1'b1;
      default:    legal = 1'b0;
    endcase
  end

  // ALU operation; bit 30 selects SUB/SRA (immediate form has no SUBI)
  always_comb begin
    alt      = ir[30];
    alu_base = ALU_ADD;
    case (f3)
      3'b000:  alu_base = (is_op && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_base = ALU_SLL;
      3'b010:  alu_base = ALU_SLT;
      3'b011:  alu_base = ALU_SLTU;
      3'b100:  alu_base = ALU_XOR;
      3'b101:  alu_base = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
  end

  assign dec_active = (state == S_DECODE) || (state == S_EXEC) ||
                      (state == S_MEM)    || (state == S_WB);

  // Decode outputs: held from DECODE through WB, idle values otherwise
  always_comb begin
    alu_ctrl   = 4'd0;
    alu_src    = 1'b0;
    imm_src    = 3'b111;
    result_src = 2'b00;
    dmem_size  = 2'b00;
    dmem_uns   = 1'b0;
    if (dec_active) begin
      if (is_op || is_opimm)  alu_ctrl = alu_base;
      else if (is_branch)     alu_ctrl = ALU_SUB;
      else                    alu_ctrl = ALU_ADD;
      alu_src = !(is_op || is_branch);
      if (is_opimm || is_load || is_jalr) imm_src = 3'b000;
      else if (is_store)                  imm_src = 3'b001;
      else if (is_branch)                 imm_src = 3'b010;
      else if (is_lui || is_auipc)        imm_src = 3'b011;
      else if (is_jal)                    imm_src = 3'b100;
      else                                imm_src = 3'b111;
      if (is_load)                 result_src = 2'b01;
      else if (is_jal || is_jalr)  result_src = 2'b10;
      else if (is_lui || is_auipc) result_src = 2'b11;
      if (is_load || is_store) dmem_size = 2'(2'd3 - f3[1:0]);
      dmem_uns = is_load && f3[2];
    end
  end

  assign waiting = ((state == S_FETCH) && !imem_ready) || ((state == S_MEM) && !dmem_ready);
  assign timeout = (MAX_WAIT != 0) && waiting && (wd == WAIT_W'(MAX_WAIT - 1));

  // Next state and strobes; strobes are forced low while reset is held
  always_comb begin
    state_nxt = state;
    wd_nxt    = '0;
    set_ill   = 1'b0;
    set_be    = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'b00;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        wd_nxt   = waiting ? wd + WAIT_W'(1) : '0;
        if (imem_ready) begin
          state_nxt = S_DECODE;
        end else if (timeout) begin
          state_nxt = S_TRAP;
          set_be    = 1'b1;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_TRAP;
          set_ill   = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_we     = 1'b1;
          pc_src    = br_cond ? 2'b01 : 2'b00;
          state_nxt = S_FETCH;
        end else if (is_load || is_store) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        wd_nxt   = waiting ? wd + WAIT_W'(1) : '0;
        if (dmem_ready) begin
          if (is_store) begin
            pc_we     = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (timeout) begin
          state_nxt = S_TRAP;
          set_be    = 1'b1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_we     = 1'b1;
        if (is_jal)       pc_src = 2'b01;
        else if (is_jalr) pc_src = 2'b10;
        state_nxt = S_FETCH;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase
    if (!reset) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      reg_write = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_FETCH;
      ir      <= IR_NOP;
      wd      <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_nxt;
      wd    <= wd_nxt;
      if ((state == S_FETCH) && imem_ready) ir <= imem_rdata;
      if (set_ill) illegal <= 1'b1;
      if (set_be)  bus_err <= 1'b1;
    end
  end

`ifdef MC_PERF_CNT_EN
  // Free-running performance counters, wrap mod 2^32
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we)           instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed cases plus random instructions and wait
// states, compared cycle by cycle against a transaction-level expected trace.
module tb_multicycle_ctrl_fsm;

  localparam int unsigned MAX_WAIT = 4;

  localparam int C_ILL = 0, C_OP = 1, C_OPI = 2, C_LD = 3, C_ST = 4, C_BR = 5,
                 C_JAL = 6, C_JALR = 7, C_LUI = 8, C_AUIPC = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        dmem_req, dmem_we, dmem_uns, dmem_ready = 1'b0;
  logic [1:0]  dmem_size;
  logic        br_cond = 1'b0;
  logic [31:0] ir_o;
  logic [3:0]  alu_ctrl;
  logic        alu_src;
  logic [2:0]  imm_src;
  logic [1:0]  result_src, pc_src;
  logic        reg_write, pc_we, illegal, bus_err;
  logic [2:0]  state_o;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_ctrl_fsm #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size), .dmem_uns(dmem_uns),
    .dmem_ready(dmem_ready), .br_cond(br_cond), .ir_o(ir_o),
    .alu_ctrl(alu_ctrl), .alu_src(alu_src), .imm_src(imm_src), .result_src(result_src),
    .reg_write(reg_write), .pc_we(pc_we), .pc_src(pc_src),
    .illegal(illegal), .bus_err(bus_err),
`ifdef MC_PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s @%0t observed=0x%0h expected=0x%0h", tag, $time, obs, exp);
    end
  endtask

  // One expected cycle: inputs to drive and outputs required
  typedef struct {
    logic [2:0]  st;
    logic        ir_rdy, d_rdy, brc;
    logic        ireq, dreq, dwe, rw, pwe;
    logic [1:0]  psrc;
    logic        ill, be;
    int          mode;        // 0 idle decode outputs, 1 instruction decode, 2 unchecked
    logic [31:0] ir;
    logic [3:0]  alu;
    logic        asrc, chk_alu, uns;
    logic [2:0]  imm;
    logic [1:0]  res, size;
  } cyc_t;

  cyc_t q[$];
  cyc_t tmpl;
  int   alu_base_tab[8] = '{0, 7, 2, 3, 4, 8, 5, 6};

  function automatic int classify(input logic [31:0] ir);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ir[14:12];
    f7 = ir[31:25];
    case (ir[6:0])
      7'h33: return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? C_OP : C_ILL;
      7'h13: return C_OPI;
      7'h03: return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? C_LD : C_ILL;
      7'h23: return (f3 inside {3'd0, 3'd1, 3'd2}) ? C_ST : C_ILL;
      7'h63: return (f3 inside {3'd2, 3'd3}) ? C_ILL : C_BR;
      7'h6F: return C_JAL;
      7'h67: return (f3 == 3'd0) ? C_JALR : C_ILL;
      7'h37: return C_LUI;
      7'h17: return C_AUIPC;
      default: return C_ILL;
    endcase
  endfunction

  function automatic cyc_t mk(input logic [2:0] st, input int mode);
    cyc_t c;
    c        = tmpl;
    c.st     = st;
    c.mode   = mode;
    c.ir_rdy = 1'($urandom);
    c.d_rdy  = 1'($urandom);
    c.brc    = 1'($urandom);
    c.ireq = 0; c.dreq = 0; c.dwe = 0; c.rw = 0; c.pwe = 0; c.psrc = 0; c.ill = 0; c.be = 0;
    return c;
  endfunction

  task automatic add_trap(input logic ill, input logic be);
    cyc_t c;
    for (int i = 0; i < 3; i++) begin
      c = mk(3'd5, 0);
      c.ill = ill;
      c.be  = be;
      q.push_back(c);
    end
  endtask

  // Expected trace of one instruction from the sequencing rules
  task automatic build(input logic [31:0] ir, input int fw, input int mw, input logic brc,
                       output bit trapped);
    int   cls;
    int   f3;
    cyc_t c;
    cls = classify(ir);
    f3  = int'(ir[14:12]);
    trapped = 0;
    tmpl.ir   = ir;
    tmpl.imm  = (cls == C_OPI || cls == C_LD || cls == C_JALR) ? 3'd0 :
                (cls == C_ST) ? 3'd1 : (cls == C_BR) ? 3'd2 :
                (cls == C_LUI || cls == C_AUIPC) ? 3'd3 : (cls == C_JAL) ? 3'd4 : 3'd7;
    tmpl.res  = (cls == C_LD) ? 2'd1 : (cls == C_JAL || cls == C_JALR) ? 2'd2 :
                (cls == C_LUI || cls == C_AUIPC) ? 2'd3 : 2'd0;
    tmpl.size = (cls == C_LD || cls == C_ST) ? 2'(3 - int'(ir[13:12])) : 2'd0;
    tmpl.uns  = (cls == C_LD) && ir[14];
    tmpl.chk_alu = (cls == C_OP || cls == C_OPI || cls == C_LD || cls == C_ST);
    tmpl.asrc = (cls != C_OP);
    tmpl.alu  = 4'd0;
    if (cls == C_OP)  tmpl.alu = 4'(alu_base_tab[f3] + ((ir[30] && (f3 == 0 || f3 == 5)) ? 1 : 0));
    if (cls == C_OPI) tmpl.alu = 4'(alu_base_tab[f3] + ((ir[30] && f3 == 5) ? 1 : 0));

    for (int i = 0; i < fw && i < int'(MAX_WAIT); i++) begin
      c = mk(3'd0, 0); c.ireq = 1; c.ir_rdy = 0; q.push_back(c);
    end
    if (fw >= int'(MAX_WAIT)) begin add_trap(0, 1); trapped = 1; return; end
    c = mk(3'd0, 0); c.ireq = 1; c.ir_rdy = 1; q.push_back(c);

    q.push_back(mk(3'd1, (cls == C_ILL) ? 2 : 1));
    if (cls == C_ILL) begin add_trap(1, 0); trapped = 1; return; end

    c = mk(3'd2, 1);
    if (cls == C_BR) begin
      c.brc = brc; c.pwe = 1; c.psrc = brc ? 2'd1 : 2'd0; q.push_back(c); return;
    end
    q.push_back(c);

    if (cls == C_LD || cls == C_ST) begin
      for (int i = 0; i < mw && i < int'(MAX_WAIT); i++) begin
        c = mk(3'd3, 1); c.dreq = 1; c.dwe = (cls == C_ST); c.d_rdy = 0; q.push_back(c);
      end
      if (mw >= int'(MAX_WAIT)) begin add_trap(0, 1); trapped = 1; return; end
      c = mk(3'd3, 1); c.dreq = 1; c.dwe = (cls == C_ST); c.d_rdy = 1;
      if (cls == C_ST) begin c.pwe = 1; c.psrc = 2'd0; q.push_back(c); return; end
      q.push_back(c);
    end

    c = mk(3'd4, 1); c.rw = 1; c.pwe = 1;
    c.psrc = (cls == C_JAL) ? 2'd1 : (cls == C_JALR) ? 2'd2 : 2'd0;
    q.push_back(c);
  endtask

  // Drive and check up to 'limit' queued cycles; entered just after a rising edge
  task automatic play(input int limit);
    cyc_t c;
    int   n = 0;
    while (q.size() > 0 && n < limit) begin
      c = q.pop_front();
      n++;
      #1;
      reset      = 1'b1;
      imem_ready = c.ir_rdy;
      imem_rdata = (c.st == 3'd0 && c.ir_rdy) ? c.ir : $urandom;
      dmem_ready = c.d_rdy;
      br_cond    = c.brc;
      #1;
      check("state", 32'(state_o), 32'(c.st));
      check("strobes", 32'({imem_req, dmem_req, reg_write, pc_we}),
                       32'({c.ireq, c.dreq, c.rw, c.pwe}));
      if (c.dreq) check("dmem_we", 32'(dmem_we), 32'(c.dwe));
      if (c.pwe)  check("pc_src", 32'(pc_src), 32'(c.psrc));
      check("traps", 32'({illegal, bus_err}), 32'({c.ill, c.be}));
      if (c.mode == 0)
        check("dec_idle", 32'({alu_ctrl, alu_src, imm_src, result_src, dmem_size, dmem_uns}),
                          32'({4'd0, 1'b0, 3'b111, 2'd0, 2'd0, 1'b0}));
      if (c.mode == 1) begin
        check("ir", ir_o, c.ir);
        check("dec", 32'({imm_src, result_src, dmem_size, dmem_uns}),
                     32'({c.imm, c.res, c.size, c.uns}));
        if (c.chk_alu) check("alu", 32'({alu_ctrl, alu_src}), 32'({c.alu, c.asrc}));
      end
      @(posedge clk);
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      #1;
      reset      = 1'b0;
      imem_ready = 1'b1;
      dmem_ready = 1'($urandom);
      br_cond    = 1'($urandom);
      #1;
      check("rst_strobes", 32'({imem_req, dmem_req, dmem_we, reg_write, pc_we}), 32'd0);
      if (k > 0) begin
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_traps", 32'({illegal, bus_err}), 32'd0);
        check("rst_ir", ir_o, 32'h0000_0013);
      end
      @(posedge clk);
    end
  endtask

  logic [6:0]  opc_tab[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  function automatic logic [31:0] rand_instr();
    logic [31:0] ir;
    int          k;
    ir = $urandom;
    k  = $urandom_range(0, 10);
    if (k < 9) ir[6:0] = opc_tab[k];
    if (ir[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0, 1:    ir[31:25] = 7'h00;
        2:       ir[31:25] = 7'h20;
        default: ;
      endcase
    end
    if (ir[6:0] == 7'h67 && $urandom_range(0, 3) != 0) ir[14:12] = 3'd0;
    return ir;
  endfunction

  function automatic int rand_wait();
    return ($urandom_range(0, 9) > 7) ? $urandom_range(4, 6) : $urandom_range(0, 2);
  endfunction

  bit tr;

  initial begin
    do_reset(2);

    build(32'h002081B3, 0, 0, 1'b0, tr); play(1000);     // ADD
    build(32'h00802283, 0, 3, 1'b0, tr); play(1000);     // LW, 3 data waits
    build(32'h00000463, 0, 0, 1'b1, tr); play(1000);     // BEQ taken
    build(32'h0000007F, 0, 0, 1'b0, tr); play(1000);     // illegal opcode
    do_reset(1);
    build(32'h00112023, 0, 9, 1'b0, tr); play(1000);     // SW with data timeout
    do_reset(1);
    build(32'h00802283, 0, 9, 1'b0, tr); play(4); q.delete();  // reset during MEM
    do_reset(1);
    build(32'h0040006F, 3, 0, 1'b0, tr); play(1000);     // JAL after fetch waits
    build(32'h000080E7, 0, 0, 1'b0, tr); play(1000);     // JALR
    build(32'h4020D193, 0, 0, 1'b0, tr); play(1000);     // SRAI
    build(32'h0000C283, 1, 2, 1'b0, tr); play(1000);     // LBU
    build(32'h00000013, 4, 0, 1'b0, tr); play(1000);     // fetch timeout
    do_reset(1);

    for (int n = 0; n < 300; n++) begin
      build(rand_instr(), rand_wait(), rand_wait(), 1'($urandom), tr);
      play(1000);
      if (tr) do_reset($urandom_range(1, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
